// File: rtl/dbg_monitor_if.sv
// Byte-level link between the debug monitor and the shared uart.
// The monitor is the master: it consumes received bytes and strobes bytes out.
interface dbg_monitor_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_re;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_busy;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output rx_re, tx_data, tx_we
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  rx_re, tx_data, tx_we
  );
endinterface

// File: rtl/dbg_monitor.sv
// Debug monitor: run/halt/step clock-enable generator, probe display mux,
// and a UART command parser that dumps a snapshot of one probe as hex text.
module dbg_monitor #(
  parameter int NUM_PROBES   = 8,
  parameter int PROBE_W      = 32,
  parameter int DIV_W        = 26,
  parameter int DEFAULT_RATE = 24,
  localparam int SEL_W       = $clog2(NUM_PROBES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PROBES*PROBE_W-1:0] probe_bus,
  input  logic [SEL_W-1:0]              sw_sel,
  input  logic                          sw_half,
  dbg_monitor_if.master                 uart,
  output logic                          cpu_ce,
  output logic [15:0]                   disp,
  output logic                          halted,
  output logic                          dump_busy
);

  localparam int RATE_W  = $clog2(DIV_W);
  localparam int NIBBLES = PROBE_W / 4;
  localparam int NCHARS  = NIBBLES + 2;
  localparam int IDX_W   = $clog2(NCHARS + 1);

  localparam logic [7:0] CMD_HALT = 8'h68;
  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_FAST = 8'h2B;
  localparam logic [7:0] CMD_SLOW = 8'h2D;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;

  localparam logic [DIV_W-1:0]  CNT_ONE  = DIV_W'(1);
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_SETTLE,
    ST_WAIT
  } tx_state_t;

  tx_state_t          tx_state;
  logic [DIV_W-1:0]   counter;
  logic [DIV_W-1:0]   terminal;
  logic [RATE_W-1:0]  rate;
  logic [SEL_W-1:0]   dump_ch;
  logic [PROBE_W-1:0] snap;
  logic [IDX_W-1:0]   idx;

  logic [PROBE_W-1:0] probe [NUM_PROBES];
  logic [PROBE_W-1:0] sel_probe;
  logic               accept;
  logic [7:0]         cmd;
  logic [7:0]         digit;
  logic               digit_ok;
  logic [3:0]         nib;
  logic [7:0]         next_char;

  always_comb begin
    for (int k = 0; k < NUM_PROBES; k++) probe[k] = probe_bus[k*PROBE_W +: PROBE_W];
  end

  // Unmatched selects (only possible when NUM_PROBES is not a power of two) read as 0.
  always_comb begin
    sel_probe = '0;
    for (int k = 0; k < NUM_PROBES; k++)
      if (sw_sel == SEL_W'(k)) sel_probe = probe[k];
  end

  // NOTE: rx_re is decoded combinationally so the byte is consumed and acted on
  // in the same cycle; a registered strobe would let a still-valid byte be taken twice.
  assign accept      = !rst && uart.rx_valid && (tx_state == ST_IDLE);
  assign uart.rx_re  = accept;
  assign cmd         = uart.rx_data;
  assign digit       = cmd - 8'h30;
  assign digit_ok    = (cmd >= 8'h30) && (cmd <= 8'h39) && (int'(digit) < NUM_PROBES);
  assign terminal    = (CNT_ONE << rate) - CNT_ONE;

  // NOTE: all state below uses non-blocking assignments so every block samples
  // the pre-edge values of the others, independent of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted  <= 1'b0;
      rate    <= RATE_W'(DEFAULT_RATE);
      counter <= '0;
      cpu_ce  <= 1'b0;
      dump_ch <= '0;
    end else begin
      cpu_ce <= 1'b0;
      if (halted) begin
        counter <= '0;
      end else if (counter == terminal) begin
        cpu_ce  <= 1'b1;
        counter <= '0;
      end else begin
        counter <= counter + CNT_ONE;
      end

      if (accept) begin
        case (cmd)
          CMD_HALT: if (!halted) begin
            halted  <= 1'b1;
            counter <= '0;
            cpu_ce  <= 1'b0;
          end
          CMD_GO: if (halted) begin
            halted  <= 1'b0;
            counter <= '0;
          end
          CMD_STEP: if (halted) cpu_ce <= 1'b1;
          // A rate change restarts the period so a shorter rate never has to
          // wait for the counter to wrap past its old, larger terminal count.
          CMD_FAST: if (rate != '0) begin
            rate    <= rate - RATE_W'(1);
            counter <= '0;
          end
          CMD_SLOW: if (rate != RATE_MAX) begin
            rate    <= rate + RATE_W'(1);
            counter <= '0;
          end
          default: if (digit_ok) dump_ch <= digit[SEL_W-1:0];
        endcase
      end
    end
  end

  assign nib = snap[PROBE_W-1 -: 4];

  always_comb begin
    if (idx < IDX_W'(NIBBLES))
      next_char = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    else if (idx == IDX_W'(NIBBLES))
      next_char = CHAR_CR;
    else
      next_char = CHAR_LF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state     <= ST_IDLE;
      dump_busy    <= 1'b0;
      uart.tx_we   <= 1'b0;
      uart.tx_data <= '0;
      idx          <= '0;
      snap         <= '0;
    end else begin
      uart.tx_we <= 1'b0;
      case (tx_state)
        ST_IDLE: if (accept && cmd == CMD_DUMP) begin
          snap      <= probe[dump_ch];
          idx       <= '0;
          dump_busy <= 1'b1;
          tx_state  <= ST_SEND;
        end
        ST_SEND: if (!uart.tx_busy) begin
          uart.tx_data <= next_char;
          uart.tx_we   <= 1'b1;
          idx          <= idx + IDX_W'(1);
          if (idx < IDX_W'(NIBBLES)) snap <= snap << 4;
          tx_state     <= ST_SETTLE;
        end
        // The uart raises tx_busy one cycle after the strobe; skip that cycle.
        ST_SETTLE: tx_state <= ST_WAIT;
        ST_WAIT: if (!uart.tx_busy) begin
          if (idx == IDX_W'(NCHARS)) begin
            dump_busy <= 1'b0;
            tx_state  <= ST_IDLE;
          end else begin
            tx_state  <= ST_SEND;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp <= '0;
    else     disp <= sw_half ? sel_probe[PROBE_W-1 -: 16] : sel_probe[15:0];
  end

endmodule
